// File: rtl/dio_pulse_sequencer.sv
// dio_pulse_sequencer: trigger-driven delay/width pulse sequencer for the TRBDS3 digital-output board
// Build macro DIO_SEQ_ILK_EN: when defined, a trigger during a frame aborts it into a latched interlock.
// Ports: i_clk/i_rst clock and synchronous active-high reset; i_beam_trg asynchronous trigger;
//   i_arm trigger accept enable; i_frame_len/i_trg_width/i_dly/i_wid frame program (CH1 in the lowest
//   CNT_W slice); i_ilk_clr interlock clear; o_do_* registered pins; o_busy frame in progress;
//   o_trg_cnt/o_miss_cnt accepted and rejected trigger counts.
module dio_pulse_sequencer #(
    parameter int CNT_W    = 32,
    parameter int SYNC_STG = 2
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_beam_trg,
    input  logic               i_arm,
    input  logic [CNT_W-1:0]   i_frame_len,
    input  logic [CNT_W-1:0]   i_trg_width,
    input  logic [4*CNT_W-1:0] i_dly,
    input  logic [4*CNT_W-1:0] i_wid,
    input  logic               i_ilk_clr,
    output logic               o_do_trg,
    output logic               o_do_ch1,
    output logic               o_do_ch2,
    output logic               o_do_ch3,
    output logic               o_do_ch4,
    output logic               o_do_interlock,
    output logic               o_busy,
    output logic [31:0]        o_trg_cnt,
    output logic [31:0]        o_miss_cnt
);
    localparam logic [1:0] IDLE = 2'd0, ARMED = 2'd1, RUN = 2'd2, ILK = 2'd3;
`ifdef DIO_SEQ_ILK_EN
    localparam bit ILK_EN = 1'b1;
`else
    localparam bit ILK_EN = 1'b0;
`endif
    logic [1:0]         state_q, state_d;
    logic [SYNC_STG-1:0] sync_q, sync_d;
    logic               prev_q, prev_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d, fl_q, fl_d, tw_q, tw_d;
    logic [4*CNT_W-1:0] dly_q, dly_d, wid_q, wid_d;
    logic [31:0]        trg_cnt_q, trg_cnt_d, miss_cnt_q, miss_cnt_d;
    logic               trg_q, trg_d;
    logic [3:0]         ch_q, ch_d;
    logic               trg_evt, last, live;

    assign trg_evt = sync_q[SYNC_STG-1] & ~prev_q;
    // A zero frame length behaves as one clock, so it also ends on the first RUN cycle.
    assign last    = (fl_q == '0) || (cnt_q == fl_q - CNT_W'(1));

    always_comb begin
        sync_d     = {sync_q[SYNC_STG-2:0], i_beam_trg};
        prev_d     = sync_q[SYNC_STG-1];
        state_d    = state_q;
        cnt_d      = state_q == RUN ? cnt_q + CNT_W'(1) : cnt_q;
        fl_d       = fl_q;
        tw_d       = tw_q;
        dly_d      = dly_q;
        wid_d      = wid_q;
        trg_cnt_d  = trg_cnt_q;
        miss_cnt_d = miss_cnt_q;
        case (state_q)
            IDLE:  state_d = i_arm ? ARMED : IDLE;
            ARMED: begin
                if (trg_evt) begin
                    state_d   = RUN;
                    cnt_d     = '0;
                    fl_d      = i_frame_len;
                    tw_d      = i_trg_width;
                    dly_d     = i_dly;
                    wid_d     = i_wid;
                    trg_cnt_d = trg_cnt_q + 32'd1;
                end else if (!i_arm) begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                if (last) state_d = i_arm ? ARMED : IDLE;
                if (trg_evt) begin
                    miss_cnt_d = miss_cnt_q + 32'd1;
                    if (ILK_EN) state_d = ILK;
                end
            end
            default: state_d = i_ilk_clr ? IDLE : ILK;
        endcase
        // An aborting trigger blanks the pins in the same edge that enters ILK.
        live  = (state_q == RUN) && !(ILK_EN && trg_evt);
        trg_d = live && (cnt_q < tw_q);
        for (int n = 0; n < 4; n++)
            ch_d[n] = live && (cnt_q >= dly_q[n*CNT_W +: CNT_W]) &&
                      ({1'b0, cnt_q} < {1'b0, dly_q[n*CNT_W +: CNT_W]} + {1'b0, wid_q[n*CNT_W +: CNT_W]});
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= IDLE;
            sync_q     <= '0;
            prev_q     <= 1'b0;
            cnt_q      <= '0;
            fl_q       <= '0;
            tw_q       <= '0;
            dly_q      <= '0;
            wid_q      <= '0;
            trg_cnt_q  <= '0;
            miss_cnt_q <= '0;
            trg_q      <= 1'b0;
            ch_q       <= '0;
        end else begin
            state_q    <= state_d;
            sync_q     <= sync_d;
            prev_q     <= prev_d;
            cnt_q      <= cnt_d;
            fl_q       <= fl_d;
            tw_q       <= tw_d;
            dly_q      <= dly_d;
            wid_q      <= wid_d;
            trg_cnt_q  <= trg_cnt_d;
            miss_cnt_q <= miss_cnt_d;
            trg_q      <= trg_d;
            ch_q       <= ch_d;
        end
    end

    assign o_do_trg       = trg_q;
    assign o_do_ch1       = ch_q[0];
    assign o_do_ch2       = ch_q[1];
    assign o_do_ch3       = ch_q[2];
    assign o_do_ch4       = ch_q[3];
    assign o_do_interlock = ILK_EN && (state_q == ILK);
    assign o_busy         = state_q == RUN;
    assign o_trg_cnt      = trg_cnt_q;
    assign o_miss_cnt     = miss_cnt_q;
endmodule

// File: tb/tb_dio_pulse_sequencer.sv
// tb_dio_pulse_sequencer: directed self-checking bench for dio_pulse_sequencer
`timescale 1ns/1ps
module tb_dio_pulse_sequencer;
    localparam int CNT_W = 32;
    logic               i_clk = 1'b0;
    logic               i_rst, i_beam_trg, i_arm, i_ilk_clr;
    logic [CNT_W-1:0]   i_frame_len, i_trg_width;
    logic [4*CNT_W-1:0] i_dly, i_wid;
    logic o_do_trg, o_do_ch1, o_do_ch2, o_do_ch3, o_do_ch4, o_do_interlock, o_busy;
    logic [31:0] o_trg_cnt, o_miss_cnt;
    int vectors = 0, miscompares = 0;
    longint fl, tw;
    longint d[4], w[4];

    dio_pulse_sequencer #(.CNT_W(CNT_W), .SYNC_STG(2)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_beam_trg(i_beam_trg), .i_arm(i_arm),
        .i_frame_len(i_frame_len), .i_trg_width(i_trg_width), .i_dly(i_dly), .i_wid(i_wid),
        .i_ilk_clr(i_ilk_clr), .o_do_trg(o_do_trg), .o_do_ch1(o_do_ch1), .o_do_ch2(o_do_ch2),
        .o_do_ch3(o_do_ch3), .o_do_ch4(o_do_ch4), .o_do_interlock(o_do_interlock),
        .o_busy(o_busy), .o_trg_cnt(o_trg_cnt), .o_miss_cnt(o_miss_cnt));

    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Expected {busy, trg, ch4..ch1} k clocks after the event cycle E; cnt = k-2 drives the pins.
    function automatic logic [5:0] pins(input longint k);
        longint feff, c;
        logic [5:0] r;
        feff = (fl == 0) ? 1 : fl;
        c    = k - 2;
        r[5] = (k >= 1) && (k <= feff);
        r[4] = (c >= 0) && (c < feff) && (c < tw);
        for (int n = 0; n < 4; n++)
            r[n] = (c >= 0) && (c < feff) && (c >= d[n]) && (c < d[n] + w[n]);
        return r;
    endfunction

    function automatic logic [5:0] pins_act();
        return {o_busy, o_do_trg, o_do_ch4, o_do_ch3, o_do_ch2, o_do_ch1};
    endfunction

    task automatic tick();
        @(negedge i_clk);
    endtask

    task automatic apply();
        i_frame_len = fl[31:0];
        i_trg_width = tw[31:0];
        i_dly = {d[3][31:0], d[2][31:0], d[1][31:0], d[0][31:0]};
        i_wid = {w[3][31:0], w[2][31:0], w[1][31:0], w[0][31:0]};
    endtask

    task automatic do_reset();
        tick();
        i_rst = 1'b1;
        tick();
        tick();
        i_rst = 1'b0;
    endtask

    // Returns at the negedge inside the event cycle E.
    task automatic fire();
        tick();
        i_beam_trg = 1'b1;
        tick();
        tick();
        i_beam_trg = 1'b0;
    endtask

    initial begin
        i_rst = 1'b0; i_beam_trg = 1'b0; i_arm = 1'b0; i_ilk_clr = 1'b0;
        i_frame_len = '0; i_trg_width = '0; i_dly = '0; i_wid = '0;
        do_reset();
        check("reset_pins", 64'(pins_act()), 64'd0);
        check("reset_trg_cnt", 64'(o_trg_cnt), 64'd0);
        check("reset_miss_cnt", 64'(o_miss_cnt), 64'd0);
        check("reset_ilk", 64'(o_do_interlock), 64'd0);

        fl = 100; tw = 10; d = '{5, 20, 0, 50}; w = '{10, 5, 0, 60};
        apply();
        i_arm = 1'b1;
        tick();
        fire();
        for (longint k = 1; k <= 103; k++) begin
            tick();
            check($sformatf("single k=%0d", k), 64'(pins_act()), 64'(pins(k)));
        end
        check("single_trg_cnt", 64'(o_trg_cnt), 64'd1);
        check("single_miss_cnt", 64'(o_miss_cnt), 64'd0);

        do_reset();
        tick();
        fire();
        for (longint k = 1; k <= 104; k++) begin
            logic [5:0] e;
            tick();
            e = pins(k);
`ifdef DIO_SEQ_ILK_EN
            if (k >= 41) e = '0;
            check($sformatf("ovr_ilk k=%0d", k), 64'(o_do_interlock), 64'(k >= 41));
`else
            check($sformatf("ovr_ilk k=%0d", k), 64'(o_do_interlock), 64'd0);
`endif
            check($sformatf("ovr k=%0d", k), 64'(pins_act()), 64'(e));
            if (k == 38) i_beam_trg = 1'b1;
            if (k == 40) i_beam_trg = 1'b0;
        end
        check("ovr_miss_cnt", 64'(o_miss_cnt), 64'd1);
        check("ovr_trg_cnt", 64'(o_trg_cnt), 64'd1);
        i_ilk_clr = 1'b1;
        tick();
        i_ilk_clr = 1'b0;
        check("clr_ilk", 64'(o_do_interlock), 64'd0);
        check("clr_busy", 64'(o_busy), 64'd0);
        tick();
        fire();
        tick();
        check("rearm_busy", 64'(o_busy), 64'd1);
        check("rearm_trg_cnt", 64'(o_trg_cnt), 64'd2);

        do_reset();
        fl = 8; tw = 2; d = '{1, 2, 3, 7}; w = '{2, 2, 2, 3};
        apply();
        tick();
        fire();
        for (longint k = 1; k <= 37; k++) begin
            longint f;
            tick();
            f = (k - 1) / 9;
            if (f > 3) f = 3;
            check($sformatf("b2b k=%0d", k), 64'(pins_act()), 64'(pins(k - 9 * f)));
            if (k == 7 || k == 16 || k == 25) i_beam_trg = 1'b1;
            if (k == 9 || k == 18 || k == 27) i_beam_trg = 1'b0;
        end
        check("b2b_trg_cnt", 64'(o_trg_cnt), 64'd4);
        check("b2b_miss_cnt", 64'(o_miss_cnt), 64'd0);

        do_reset();
        fl = 100; tw = 10; d = '{5, 20, 0, 50}; w = '{10, 5, 0, 60};
        apply();
        tick();
        fire();
        for (longint k = 1; k <= 103; k++) begin
            tick();
            check($sformatf("shadow k=%0d", k), 64'(pins_act()), 64'(pins(k)));
            if (k == 3) begin
                i_dly[31:0] = 32'd30;
                i_arm = 1'b0;
            end
        end
        fire();
        for (int k = 1; k <= 4; k++) begin
            tick();
            check($sformatf("disarm_busy k=%0d", k), 64'(o_busy), 64'd0);
        end
        check("disarm_trg_cnt", 64'(o_trg_cnt), 64'd1);

        apply();
        i_arm = 1'b1;
        tick();
        fire();
        for (longint k = 1; k <= 20; k++) tick();
        check("pre_rst_pins", 64'(pins_act()), 64'(pins(20)));
        i_rst = 1'b1;
        tick();
        check("rst_pins", 64'(pins_act()), 64'd0);
        check("rst_trg_cnt", 64'(o_trg_cnt), 64'd0);
        check("rst_miss_cnt", 64'(o_miss_cnt), 64'd0);
        i_rst = 1'b0;

        fl = 0; tw = 5; d = '{64'hFFFF_FFFF, 0, 0, 0}; w = '{4, 1, 0, 0};
        apply();
        tick();
        fire();
        for (longint k = 1; k <= 5; k++) begin
            tick();
            check($sformatf("fl0 k=%0d", k), 64'(pins_act()), 64'(pins(k)));
        end
        fl = 6; tw = 3; d = '{64'hFFFF_FFFF, 64'hFFFF_FFFE, 0, 0}; w = '{4, 4, 0, 0};
        apply();
        fire();
        for (longint k = 1; k <= 8; k++) begin
            tick();
            check($sformatf("nowrap k=%0d", k), 64'(pins_act()), 64'(pins(k)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
